// File: rtl/input_cmd_queue_if.sv
// Command handshake between the input queue and the game engine.
//   cmd_valid : head command present (queue -> engine)
//   cmd_code  : head command, 00 left, 01 right, 10 CW, 11 CCW (queue -> engine)
//   cmd_ready : engine accepts the head command this cycle (engine -> queue)
// master = queue side, slave = game engine side.
interface input_cmd_queue_if;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/input_cmd_queue.sv
// Input command queue: arbitrates debounced move pulses (left > right > cw > ccw),
// buffers at most one move per cycle in a small FIFO for the game engine, counts
// discarded moves, and turns rst_pulse into a one-cycle game_rst.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   left/right/cw/ccw_pulse      one-cycle move requests
//   rst_pulse                    one-cycle game-reset request
//   cmd (master)                 cmd_valid / cmd_code / cmd_ready handshake
//   game_rst                     one-cycle game-reset pulse
//   queue_full                   occupancy == DEPTH
//   drop_count                   saturating count of discarded moves
module input_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 left_pulse,
  input  logic                 right_pulse,
  input  logic                 cw_pulse,
  input  logic                 ccw_pulse,
  input  logic                 rst_pulse,
  input_cmd_queue_if.master    cmd,
  output logic                 game_rst,
  output logic                 queue_full,
  output logic [7:0]           drop_count
);

  localparam logic [PTRW:0] FULL_OCC = (PTRW+1)'(DEPTH);

  logic [1:0]      mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   occ;

  logic       any_move, pop, push;
  logic [1:0] sel_code;
  logic [2:0] n_moves, drop_inc;
  logic [8:0] drop_sum;
  logic [7:0] drop_next;

  assign cmd.cmd_valid = (occ != '0);
  assign cmd.cmd_code  = mem[rd_ptr];
  assign queue_full    = (occ == FULL_OCC);

  always_comb begin
    n_moves  = {2'b0, left_pulse} + {2'b0, right_pulse} + {2'b0, cw_pulse} + {2'b0, ccw_pulse};
    any_move = (n_moves != 3'd0);
    sel_code = 2'b00;
    if (left_pulse)       sel_code = 2'b00;
    else if (right_pulse) sel_code = 2'b01;
    else if (cw_pulse)    sel_code = 2'b10;
    else if (ccw_pulse)   sel_code = 2'b11;
    pop  = cmd.cmd_valid & cmd.cmd_ready;
    // A full queue still takes the move if the head leaves in the same cycle.
    push = any_move & (~queue_full | pop);
    // Losers of arbitration, plus the winner itself if it found no room.
    drop_inc = 3'd0;
    if (any_move) drop_inc = n_moves - 3'd1 + {2'b0, ~push};
    drop_sum  = {1'b0, drop_count} + {6'b0, drop_inc};
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      drop_count <= '0;
      game_rst   <= 1'b0;
    end else begin
      game_rst <= rst_pulse;
      if (rst_pulse) begin
        // Game reset overrides moves and pops in the same cycle; nothing is counted.
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        occ        <= '0;
        drop_count <= '0;
      end else begin
        drop_count <= drop_next;
        if (push) wr_ptr <= wr_ptr + PTRW'(1);
        if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
        if (push && !pop)      occ <= occ + (PTRW+1)'(1);
        else if (pop && !push) occ <= occ - (PTRW+1)'(1);
      end
    end
  end

  // Storage is not reset; cmd_code is meaningless while cmd_valid is low.
  always_ff @(posedge clk) begin
    if (push && !rst_pulse) mem[wr_ptr] <= sel_code;
  end

endmodule

// File: tb/tb_input_cmd_queue.sv
module tb_input_cmd_queue;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       left_pulse, right_pulse, cw_pulse, ccw_pulse, rst_pulse;
  logic       game_rst, queue_full;
  logic [7:0] drop_count;
  int         checks = 0;
  int         failures = 0;

  input_cmd_queue_if cif ();

  input_cmd_queue #(.DEPTH(4), .PTRW(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_pulse  (left_pulse),
    .right_pulse (right_pulse),
    .cw_pulse    (cw_pulse),
    .ccw_pulse   (ccw_pulse),
    .rst_pulse   (rst_pulse),
    .cmd         (cif.master),
    .game_rst    (game_rst),
    .queue_full  (queue_full),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       l, r, cw, ccw, rp, rdy;
    logic       ev;
    logic [1:0] ec;
    logic       ef;
    logic [7:0] ed;
    logic       eg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic l, r, cw, ccw, rp, rdy,
                     input logic ev, input logic [1:0] ec, input logic ef,
                     input logic [7:0] ed, input logic eg);
    vec_t v;
    v.l = l; v.r = r; v.cw = cw; v.ccw = ccw; v.rp = rp; v.rdy = rdy;
    v.ev = ev; v.ec = ec; v.ef = ef; v.ed = ed; v.eg = eg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic l, r, cw, ccw, rp, rdy);
    left_pulse = l; right_pulse = r; cw_pulse = cw; ccw_pulse = ccw;
    rst_pulse = rp; cif.cmd_ready = rdy;
  endtask

  // Apply one cycle of inputs at negedge, return after the next posedge + 1.
  task automatic step(input logic l, r, cw, ccw, rp, rdy);
    @(negedge clk);
    drive(l, r, cw, ccw, rp, rdy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   l  r  cw ccw rp rdy   ev ec     ef ed  eg
    add(0, 0, 1, 0, 0, 0,    1, 2'b10, 0, 0, 0);  // cw -> valid one cycle later
    add(0, 0, 0, 0, 0, 0,    1, 2'b10, 0, 0, 0);  // held while not ready
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 0);  // pop -> empty
    add(1, 0, 0, 0, 0, 0,    1, 2'b00, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,    1, 2'b00, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,    1, 2'b00, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,    1, 2'b00, 1, 0, 0);  // full
    add(1, 0, 0, 0, 0, 0,    1, 2'b00, 1, 1, 0);  // 5th move dropped
    add(0, 0, 0, 0, 0, 1,    1, 2'b01, 0, 1, 0);  // drain in order
    add(0, 0, 0, 0, 0, 1,    1, 2'b10, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,    1, 2'b11, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0,    1, 2'b00, 0, 1, 0);  // refill
    add(0, 1, 0, 0, 0, 0,    1, 2'b00, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0,    1, 2'b00, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,    1, 2'b00, 1, 1, 0);
    add(1, 0, 0, 0, 0, 1,    1, 2'b01, 1, 1, 0);  // push+pop on full: stays full
    add(0, 0, 0, 0, 0, 1,    1, 2'b10, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,    1, 2'b11, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,    1, 2'b00, 0, 1, 0);  // new left entry last
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0,    1, 2'b00, 0, 3, 0);  // 3 moves at once: +2 drops
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 3, 0);
    add(0, 1, 0, 0, 0, 0,    1, 2'b01, 0, 3, 0);
    add(0, 0, 1, 0, 0, 0,    1, 2'b01, 0, 3, 0);
    add(0, 0, 0, 1, 0, 0,    1, 2'b01, 0, 3, 0);
    add(0, 1, 0, 0, 1, 0,    0, 2'b00, 0, 0, 1);  // rst_pulse wins over right
    add(0, 0, 0, 0, 0, 0,    0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,    0, 2'b00, 0, 0, 1);  // back-to-back game_rst
    add(0, 0, 0, 0, 1, 0,    0, 2'b00, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,    0, 2'b00, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 0);  // ready while empty ignored
    add(0, 1, 0, 0, 0, 0,    1, 2'b01, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,    0, 2'b00, 0, 0, 0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset valid", cif.cmd_valid, 0);
    chk("reset full", queue_full, 0);
    chk("reset drop", drop_count, 0);
    chk("reset game_rst", game_rst, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].l, vecs[i].r, vecs[i].cw, vecs[i].ccw, vecs[i].rp, vecs[i].rdy);
      chk($sformatf("v%0d valid", i), cif.cmd_valid, vecs[i].ev);
      if (vecs[i].ev) chk($sformatf("v%0d code", i), cif.cmd_code, vecs[i].ec);
      chk($sformatf("v%0d full", i), queue_full, vecs[i].ef);
      chk($sformatf("v%0d drop", i), drop_count, vecs[i].ed);
      chk($sformatf("v%0d game_rst", i), game_rst, vecs[i].eg);
    end

    // Saturation: fill, then 300 dropped lefts.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    chk("sat full", queue_full, 1);
    for (int i = 1; i <= 300; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (i == 100) chk("sat drop100", drop_count, 100);
    end
    chk("sat drop300", drop_count, 255);
    step(1, 1, 0, 0, 0, 0);
    chk("sat hold", drop_count, 255);

    // Mid-stream rst_n: outputs clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async valid", cif.cmd_valid, 0);
    chk("async full", queue_full, 0);
    chk("async drop", drop_count, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0, 0);
    chk("resume valid", cif.cmd_valid, 1);
    chk("resume code", cif.cmd_code, 2);

    // game_rst also clears asynchronously.
    step(0, 0, 0, 0, 1, 0);
    chk("grst high", game_rst, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async game_rst", game_rst, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_cmd_queue.md
INPUT_CMD_QUEUE -- requirements
Module: input_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count, power of two, 2..16.
REQ-002 SHALL have parameter PTRW, default 2, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port left_pulse  input  1  one-cycle move-left request from the debouncer.
REQ-006 SHALL have port right_pulse  input  1  one-cycle move-right request.
REQ-007 SHALL have port cw_pulse  input  1  one-cycle rotate-clockwise request.
REQ-008 SHALL have port ccw_pulse  input  1  one-cycle rotate-counterclockwise request.
REQ-009 SHALL have port rst_pulse  input  1  one-cycle game-reset request.
REQ-010 SHALL have port cmd_ready  input  1  game engine accepts the head command this cycle.
REQ-011 SHALL have port cmd_valid  output  1  head command present.
REQ-012 SHALL have port cmd_code  output  2  head command: 00 left, 01 right, 10 CW, 11 CCW.
REQ-013 SHALL have port game_rst  output  1  one-cycle game-reset pulse.
REQ-014 SHALL have port queue_full  output  1  occupancy equals DEPTH.
REQ-015 SHALL have port drop_count  output  8  saturating count of discarded move requests.

Function
REQ-016 SHALL hold FIFO state in a circular buffer with write pointer, read pointer and PTRW+1-bit occupancy counter.
REQ-017 SHALL select at most one move per cycle, priority left > right > cw > ccw.
REQ-018 SHALL count each unselected simultaneous move pulse as a drop, i.e. drop_count += (number of move pulses asserted) - 1.
REQ-019 SHALL write the selected code at the write pointer on the next rising edge when occupancy < DEPTH, or when occupancy = DEPTH and a pop occurs in the same cycle.
REQ-020 SHALL discard the selected move and increment drop_count by 1 when occupancy = DEPTH and no pop occurs that cycle.
REQ-021 SHALL define a pop as cmd_valid & cmd_ready; a pop advances the read pointer and decrements occupancy.
REQ-022 SHALL leave occupancy unchanged on a simultaneous push and pop.
REQ-023 SHALL drive cmd_valid = (occupancy != 0) and cmd_code = buffer[read pointer], combinationally from registered state.
REQ-024 SHALL give push-to-valid latency of exactly one cycle: a pulse at edge N makes cmd_valid high after edge N+1 when the queue was empty.
REQ-025 SHALL hold cmd_code and cmd_valid stable while cmd_valid = 1 and cmd_ready = 0.
REQ-026 SHALL ignore cmd_ready when cmd_valid = 0 and not change pointers.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL saturate drop_count at 255; further drops leave it at 255.
REQ-029 SHALL, on rst_pulse, at the next edge: clear occupancy and both pointers, clear drop_count, and assert game_rst for exactly that one cycle.
REQ-030 SHALL give rst_pulse precedence over all move pulses and pops in the same cycle; those moves are discarded and not counted.
REQ-031 SHALL produce one game_rst cycle per rst_pulse cycle; back-to-back rst_pulse yields back-to-back game_rst.
REQ-032 SHALL drive queue_full = (occupancy == DEPTH), registered-state derived.

Reset
REQ-033 SHALL, while rst_n = 0, force occupancy 0, pointers 0, drop_count 0, game_rst 0, hence cmd_valid 0, queue_full 0.
REQ-034 SHALL leave buffer contents unreset; cmd_code is don't-care while cmd_valid = 0.
REQ-035 SHALL resume normal operation on the first rising edge after rst_n deasserts; an rst_n assertion mid-operation discards all queued commands.

Verification
REQ-036 SHALL cover: cw_pulse once, cmd_ready=0 -> cmd_valid=1, cmd_code=10 one cycle later and held until cmd_ready=1, then cmd_valid=0.
REQ-037 SHALL cover: left, right, cw, ccw on separate cycles, cmd_ready=0 -> queue_full=1; a 5th left_pulse -> drop_count=1; drain gives codes 00,01,10,11 in order.
REQ-038 SHALL cover: full queue, left_pulse with cmd_ready=1 same cycle -> queue_full stays 1, drop_count unchanged, the new 00 entry appears last.
REQ-039 SHALL cover: left+cw+ccw in one cycle -> one entry 00 queued, drop_count=2.
REQ-040 SHALL cover: 3 entries queued, rst_pulse with right_pulse same cycle -> game_rst high one cycle, cmd_valid=0, drop_count=0, no entry queued.
REQ-041 SHALL cover: 300 drops with queue full -> drop_count=255; rst_n low mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.
